// File: rtl/demux_router_if.sv
// demux_router_if
//   Bundles the router's handshake and data signals: one tagged valid/ready
//   input stream and three valid/ready output channels (a, b, c).
//   Parameter: WIDTH - data width of the input word and of each channel.
//   Modports:
//     master - the surrounding system. It drives in_valid/in_data/in_sel and
//              out_ready, and observes in_ready, out_valid and out_data_*.
//     slave  - the router itself, which takes the mirror-image view.
interface demux_router_if #(
  parameter int WIDTH = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic [WIDTH-1:0] out_data_a;
  logic [WIDTH-1:0] out_data_b;
  logic [WIDTH-1:0] out_data_c;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data_a, out_data_b, out_data_c
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data_a, out_data_b, out_data_c
  );
endinterface

// File: rtl/demux_router.sv
// demux_router
//   Registered 1-to-3 demultiplexer. Each accepted input word is steered by
//   in_sel to channel a (0), b (1) or c (2). Each channel has a one-entry
//   holding register. Words tagged 3 are accepted, discarded and counted in a
//   saturating drop counter.
//   Parameters: WIDTH (data width), CNT_W (drop counter width).
//   Ports:
//     clk      - rising-edge clock
//     rst      - synchronous active-high reset; clears every channel and the counter
//     bus      - demux_router_if.slave: in_valid/in_ready/in_data/in_sel,
//                out_valid[2:0]/out_ready[2:0], out_data_a/b/c
//     drop_cnt - number of sel=3 words dropped, saturating at 2^CNT_W-1
//     sel_err  - sticky flag, set once any sel=3 word is accepted. This port
//                is present only when DEMUX_ROUTER_SEL_ERR_EN is defined.
module demux_router #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  demux_router_if.slave      bus,
`ifdef DEMUX_ROUTER_SEL_ERR_EN
  output logic               sel_err,
`endif
  output logic [CNT_W-1:0]   drop_cnt
);

  logic [2:0]       full;
  logic [WIDTH-1:0] data_q [3];
  logic             ready_sel;
  logic             in_ready;
  logic             accept;
  logic             drop;

  // Readiness depends only on the selected channel. A full channel can still
  // take a word if its consumer drains it in the same cycle. A case statement
  // keeps sel=3 from indexing past the 3-entry full vector.
  always_comb begin
    ready_sel = 1'b1;
    case (bus.in_sel)
      2'd0:    ready_sel = !full[0] | bus.out_ready[0];
      2'd1:    ready_sel = !full[1] | bus.out_ready[1];
      2'd2:    ready_sel = !full[2] | bus.out_ready[2];
      default: ready_sel = 1'b1;
    endcase
  end

  assign in_ready = !rst && ready_sel;
  assign accept   = bus.in_valid && in_ready;
  assign drop     = accept && (bus.in_sel == 2'd3);

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = full;
  assign bus.out_data_a = data_q[0];
  assign bus.out_data_b = data_q[1];
  assign bus.out_data_c = data_q[2];

  // Channel registers. A fill takes priority over a drain, so a channel
  // that is both filled and drained in one cycle stays full with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      for (int i = 0; i < 3; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (accept && (bus.in_sel == 2'(i))) begin
          full[i]   <= 1'b1;
          data_q[i] <= bus.in_data;
        end else if (full[i] && bus.out_ready[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Drop counter. It stops at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

`ifdef DEMUX_ROUTER_SEL_ERR_EN
  // Sticky error flag. Only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (drop) begin
      sel_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router
//   Directed, table-driven testbench for demux_router with WIDTH=3 and CNT_W=8.
//   A vector table covers single transfers, back-to-back streaming, stall and
//   bypass, drops and reset. Hand-written sequences cover drop-counter
//   saturation and reset during a transfer. Define DEMUX_ROUTER_SEL_ERR_EN to
//   exercise the sel_err flag as well.
module tb_demux_router;

  localparam int WIDTH = 3;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] drop_cnt;
`ifdef DEMUX_ROUTER_SEL_ERR_EN
  logic             sel_err;
`endif

  demux_router_if #(.WIDTH(WIDTH)) bus ();

  demux_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
`ifdef DEMUX_ROUTER_SEL_ERR_EN
    .sel_err  (sel_err),
`endif
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             in_valid;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       out_ready;
    logic             exp_ready;
    logic [2:0]       exp_valid;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    logic [WIDTH-1:0] exp_c;
    logic [CNT_W-1:0] exp_drop;
  } vec_t;

  int vecCount = 0;
  int missCount = 0;

  function automatic vec_t mkVec(logic r, logic v, logic [1:0] s, logic [WIDTH-1:0] d,
                                 logic [2:0] ordy, logic er, logic [2:0] ev,
                                 logic [WIDTH-1:0] ea, logic [WIDTH-1:0] eb,
                                 logic [WIDTH-1:0] ec, logic [CNT_W-1:0] edrop);
    vec_t t;
    t.rst = r; t.in_valid = v; t.in_sel = s; t.in_data = d; t.out_ready = ordy;
    t.exp_ready = er; t.exp_valid = ev; t.exp_a = ea; t.exp_b = eb; t.exp_c = ec;
    t.exp_drop = edrop;
    return t;
  endfunction

  // Drive one cycle's inputs just after a rising edge. Then check the
  // combinational in_ready before the next edge.
  task automatic applyStimulus(input string tag, input logic r, input logic v,
                               input logic [1:0] s, input logic [WIDTH-1:0] d,
                               input logic [2:0] ordy, input logic expReady);
    rst           = r;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #2;
    vecCount++;
    if (bus.in_ready !== expReady) begin
      missCount++;
      $display("[TB] FAIL %s in_ready: got %b expected %b", tag, bus.in_ready, expReady);
    end
  endtask

  // Advance through the rising edge. Then compare the registered outputs.
  task automatic checkOutput(input string tag, input logic [2:0] ev,
                             input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                             input logic [WIDTH-1:0] ec, input logic [CNT_W-1:0] edrop);
    @(posedge clk);
    #1;
    vecCount++;
    if (bus.out_valid !== ev) begin
      missCount++;
      $display("[TB] FAIL %s out_valid: got %b expected %b", tag, bus.out_valid, ev);
    end
    if (bus.out_data_a !== ea) begin
      missCount++;
      $display("[TB] FAIL %s out_data_a: got %0d expected %0d", tag, bus.out_data_a, ea);
    end
    if (bus.out_data_b !== eb) begin
      missCount++;
      $display("[TB] FAIL %s out_data_b: got %0d expected %0d", tag, bus.out_data_b, eb);
    end
    if (bus.out_data_c !== ec) begin
      missCount++;
      $display("[TB] FAIL %s out_data_c: got %0d expected %0d", tag, bus.out_data_c, ec);
    end
    if (drop_cnt !== edrop) begin
      missCount++;
      $display("[TB] FAIL %s drop_cnt: got %0d expected %0d", tag, drop_cnt, edrop);
    end
  endtask

`ifdef DEMUX_ROUTER_SEL_ERR_EN
  task automatic checkSelErr(input string tag, input logic exp);
    vecCount++;
    if (sel_err !== exp) begin
      missCount++;
      $display("[TB] FAIL %s sel_err: got %b expected %b", tag, sel_err, exp);
    end
  endtask
`endif

  vec_t vecs [17];

  initial begin
    //                 rst v  sel  data ordy     rdy  valid   a  b  c  drop
    vecs[0]  = mkVec(1, 0, 2'd0, 3'd0, 3'b111, 0, 3'b000, 0, 0, 0, 0);  // reset
    vecs[1]  = mkVec(0, 1, 2'd0, 3'd5, 3'b111, 1, 3'b001, 5, 0, 0, 0);  // a <- 5
    vecs[2]  = mkVec(0, 0, 2'd0, 3'd0, 3'b111, 1, 3'b000, 5, 0, 0, 0);  // a drained
    vecs[3]  = mkVec(0, 1, 2'd1, 3'd1, 3'b111, 1, 3'b010, 5, 1, 0, 0);  // b stream 1
    vecs[4]  = mkVec(0, 1, 2'd1, 3'd2, 3'b111, 1, 3'b010, 5, 2, 0, 0);  // b stream 2
    vecs[5]  = mkVec(0, 1, 2'd1, 3'd3, 3'b111, 1, 3'b010, 5, 3, 0, 0);  // b stream 3
    vecs[6]  = mkVec(0, 1, 2'd1, 3'd4, 3'b111, 1, 3'b010, 5, 4, 0, 0);  // b stream 4
    vecs[7]  = mkVec(0, 0, 2'd1, 3'd0, 3'b111, 1, 3'b000, 5, 4, 0, 0);  // b drained
    vecs[8]  = mkVec(0, 1, 2'd2, 3'd6, 3'b011, 1, 3'b100, 5, 4, 6, 0);  // c <- 6, stalled
    vecs[9]  = mkVec(0, 1, 2'd2, 3'd7, 3'b011, 0, 3'b100, 5, 4, 6, 0);  // c busy, 7 stalls
    vecs[10] = mkVec(0, 1, 2'd0, 3'd2, 3'b011, 1, 3'b101, 2, 4, 6, 0);  // a passes
    vecs[11] = mkVec(0, 1, 2'd2, 3'd7, 3'b111, 1, 3'b100, 2, 4, 7, 0);  // c fill+drain, a drain
    vecs[12] = mkVec(0, 0, 2'd2, 3'd0, 3'b111, 1, 3'b000, 2, 4, 7, 0);  // all drained
    vecs[13] = mkVec(0, 1, 2'd3, 3'd5, 3'b000, 1, 3'b000, 2, 4, 7, 1);  // drop 1
    vecs[14] = mkVec(0, 1, 2'd3, 3'd5, 3'b000, 1, 3'b000, 2, 4, 7, 2);  // drop 2
    vecs[15] = mkVec(1, 1, 2'd3, 3'd5, 3'b000, 0, 3'b000, 0, 0, 0, 0);  // reset clears all
    vecs[16] = mkVec(0, 0, 2'd3, 3'd1, 3'b000, 1, 3'b000, 0, 0, 0, 0);  // idle sel=3 no count

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 3'b000;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 17; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].rst, vecs[i].in_valid, vecs[i].in_sel,
                    vecs[i].in_data, vecs[i].out_ready, vecs[i].exp_ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_a, vecs[i].exp_b,
                  vecs[i].exp_c, vecs[i].exp_drop);
    end

    // Drop-counter saturation: 300 dropped words must stop the count at 255.
    $display("[TB] drop saturation");
`ifdef DEMUX_ROUTER_SEL_ERR_EN
    checkSelErr("sel_err_pre", 1'b0);
`endif
    for (int i = 0; i < 300; i++) begin
      applyStimulus($sformatf("sat%0d", i), 1'b0, 1'b1, 2'd3, 3'(i), 3'b111, 1'b1);
      @(posedge clk);
      #1;
`ifdef DEMUX_ROUTER_SEL_ERR_EN
      if (i == 0) checkSelErr("sel_err_first_drop", 1'b1);
`endif
      if (i == 0 || i == 254 || i == 299) begin
        vecCount++;
        if (drop_cnt !== ((i >= 254) ? 8'd255 : 8'(i + 1))) begin
          missCount++;
          $display("[TB] FAIL sat%0d drop_cnt: got %0d expected %0d", i, drop_cnt,
                   (i >= 254) ? 255 : i + 1);
        end
      end
    end
    applyStimulus("sat_idle", 1'b0, 1'b0, 2'd0, 3'd0, 3'b111, 1'b1);
    checkOutput("sat_idle", 3'b000, 0, 0, 0, 8'd255);

    // Reset while all three channels hold words that nobody is taking.
    $display("[TB] mid-transfer reset");
    applyStimulus("load_a", 1'b0, 1'b1, 2'd0, 3'd1, 3'b000, 1'b1);
    checkOutput("load_a", 3'b001, 1, 0, 0, 8'd255);
    applyStimulus("load_b", 1'b0, 1'b1, 2'd1, 3'd2, 3'b000, 1'b1);
    checkOutput("load_b", 3'b011, 1, 2, 0, 8'd255);
    applyStimulus("load_c", 1'b0, 1'b1, 2'd2, 3'd3, 3'b000, 1'b1);
    checkOutput("load_c", 3'b111, 1, 2, 3, 8'd255);
    applyStimulus("a_blocked", 1'b0, 1'b1, 2'd0, 3'd6, 3'b000, 1'b0);
    checkOutput("a_blocked", 3'b111, 1, 2, 3, 8'd255);
    applyStimulus("rst_mid", 1'b1, 1'b0, 2'd0, 3'd0, 3'b000, 1'b0);
    checkOutput("rst_mid", 3'b000, 0, 0, 0, 8'd0);
`ifdef DEMUX_ROUTER_SEL_ERR_EN
    checkSelErr("sel_err_after_rst", 1'b0);
`endif
    applyStimulus("post_rst_b", 1'b0, 1'b1, 2'd1, 3'd4, 3'b000, 1'b1);
    checkOutput("post_rst_b", 3'b010, 0, 4, 0, 8'd0);
    applyStimulus("hold_b", 1'b0, 1'b0, 2'd1, 3'd0, 3'b000, 1'b0);
    checkOutput("hold_b", 3'b010, 0, 4, 0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Registered 1-to-3 demultiplexer: the return path of the 3-input selector mux.
- Takes one valid/ready input stream tagged with a 2-bit select and steers each accepted word to one of three output channels.
- Each channel has its own valid/ready handshake and a one-entry holding register.
- Select value 3 is an invalid destination: the word is accepted, discarded and counted.

Parameters:
- WIDTH, 3, data width of input and each output channel.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  router can accept this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination: 0=a, 1=b, 2=c, 3=drop.
- out_valid  output  3  per-channel valid; bit0=a, bit1=b, bit2=c.
- out_ready  input  3  per-channel ready from consumers.
- out_data_a  output  WIDTH  channel a data.
- out_data_b  output  WIDTH  channel b data.
- out_data_c  output  WIDTH  channel c data.
- drop_cnt  output  CNT_W  count of words dropped for sel=3, saturating.

Behaviour:
- Reset: synchronous, active-high. On a clock edge with rst=1:
  - out_valid=0; out_data_a, out_data_b and out_data_c=0; drop_cnt=0.
  - Any buffered words are discarded, including during a mid-transfer reset.
  - in_ready is 0 while rst=1.
- Channel state: each channel i holds a register pair (full_i, data_i). out_valid[i]=full_i and out_data_x=data_i, both driven straight from flops.
- in_ready (combinational from in_sel, full and out_ready):
  - in_sel=3: in_ready=1.
  - Otherwise: in_ready = !full[in_sel] | out_ready[in_sel].
- Accept: in_valid & in_ready. There is no dependence on channels other than the selected one.
- Latency: a word accepted in cycle N appears on its channel with out_valid=1 in cycle N+1.
- Drain: out_valid[i] & out_ready[i] clears full_i at the next edge, unless a new word for channel i is accepted in the same cycle.
- Simultaneous drain and fill on the same channel: data_i takes the new word and full_i stays 1. This sustains one word per cycle per channel.
- Fill and drain on different channels in the same cycle: the two operations are independent.
- While out_valid[i]=1 and out_ready[i]=0:
  - data_i and out_valid[i] are held stable.
  - Input words for channel i stall through in_ready=0.
  - Words for other channels still pass.
- in_sel=3 accepted: no channel changes. drop_cnt increments by 1 and saturates at 2^CNT_W-1, with no wrap.
- in_data and in_sel are don't-care when in_valid=0. Nothing changes on the input side.
- out_ready is permitted to depend on out_valid. in_valid must not depend on in_ready.

Optional Feature:
- Macro: DEMUX_ROUTER_SEL_ERR_EN.
- Defined:
  - Adds output port sel_err (1 bit).
  - sel_err is a sticky flag set at the edge after the first accepted sel=3 word.
  - Cleared only by rst; reset value 0.
- Undefined: the port is absent and no flop is added. drop_cnt behaviour is identical in both builds.

Test Plan:
- Reset, then in_valid=1, sel=0, data=3'b101, out_ready=3'b111: next cycle out_valid=3'b001, out_data_a=5, and out_valid returns to 0 the following cycle.
- Back-to-back sel=1 words 1,2,3,4 with out_ready[1]=1: out_data_b shows 1,2,3,4 on consecutive cycles, in_ready stays 1 and no word is lost.
- Stall channel c (out_ready[2]=0) after loading 6, then send sel=2 data 7:
  - in_ready=0 and out_data_c holds 6.
  - A concurrent sel=0 word 2 passes to a.
  - Raising out_ready[2] lets 7 enter the cycle after 6 is taken.
- 300 words with sel=3 and CNT_W=8: drop_cnt saturates at 255, out_valid stays 0. With DEMUX_ROUTER_SEL_ERR_EN, sel_err=1 from the edge after the first drop.
- Load a=1, b=2 and c=3 with all out_ready=0, then assert rst for one cycle:
  - out_valid=0, all data=0, drop_cnt=0.
  - A new sel=1 word 4 then appears on b with 1-cycle latency.
